// File: rtl/arm_mem_pkg.sv
// Shared types and default widths for the unified-SRAM arbiter of the ARM pipeline.
package arm_mem_pkg;
  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RESP} arb_state_e;
  typedef enum logic {SRC_IF, SRC_MEM} arb_src_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and SRAM signals of the arbiter; slave = arbiter side, master = requesters + SRAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              freeze;
  logic              sram_cs;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_cs, sram_we, sram_addr, sram_wdata
  );

  modport master (
    output if_req, if_addr, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, sram_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, freeze,
           sram_cs, sram_we, sram_addr, sram_wdata
  );
endinterface

// File: rtl/mem_wait_counter.sv
// SRAM wait-cycle counter: cleared outside an access, saturates at WAIT_CYCLES-1 (done).
module mem_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                 cnt <= '0;
    else if (clear)           cnt <= '0;
    else if (enable && !done) cnt <= cnt + CW'(1);
  end

  assign done = (cnt == LAST);
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported SRAM between fetch and memory stage; freezes the pipeline while busy.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate grants on simultaneous requests (default: data first).
module mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  arb_state_e        state, state_nx;
  arb_src_e          src_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic              data_req, grant_mem, grant_if, in_acc, done;

  assign data_req = bus.mem_rd_en | bus.mem_wr_en;
  assign in_acc   = (state == D_ACC) || (state == I_ACC);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  arb_src_e last_grant;

  // A lone request wins outright; on a tie the source not granted last wins.
  assign grant_mem = data_req && (!bus.if_req || last_grant == SRC_IF);

  always_ff @(posedge clk) begin
    if (!rst)                          last_grant <= SRC_IF;
    else if (state == IDLE && grant_mem) last_grant <= SRC_MEM;
    else if (state == IDLE && grant_if)  last_grant <= SRC_IF;
  end
`else
  assign grant_mem = data_req;
`endif
  assign grant_if = bus.if_req && !grant_mem;

  mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (!in_acc),
    .enable(in_acc),
    .done  (done)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (grant_mem)     state_nx = D_ACC;
                    else if (grant_if) state_nx = I_ACC;
      D_ACC, I_ACC: if (done)          state_nx = RESP;
      RESP:                            state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      src_q       <= SRC_IF;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant_mem) begin
        src_q   <= SRC_MEM;
        wr_q    <= bus.mem_wr_en;
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
      end else if (state == IDLE && grant_if) begin
        src_q  <= SRC_IF;
        wr_q   <= 1'b0;
        addr_q <= bus.if_addr;
      end
      // Writes leave the last read word on mem_rdata.
      if (state == I_ACC && done)          if_rdata_q  <= bus.sram_rdata;
      if (state == D_ACC && done && !wr_q) mem_rdata_q <= bus.sram_rdata;
    end
  end

  assign bus.sram_cs    = in_acc;
  assign bus.sram_we    = (state == D_ACC) && wr_q;
  assign bus.sram_addr  = addr_q;
  assign bus.sram_wdata = wdata_q;
  assign bus.if_ready   = (state == RESP) && (src_q == SRC_IF);
  assign bus.mem_ready  = (state == RESP) && (src_q == SRC_MEM);
  assign bus.if_rdata   = if_rdata_q;
  assign bus.mem_rdata  = mem_rdata_q;
  // Gated by reset so a held request does not stall the pipeline during reset.
  assign bus.freeze     = rst && (((state == IDLE) && (data_req || bus.if_req)) || in_acc);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (WAIT_CYCLES=2); round-robin scenario under MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
  import arm_mem_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] mem_q[$];
  arb_src_e      grants[$];

  // SRAM model, word-indexed by addr[9:2]; preload port used while the DUT is idle
  logic [DW-1:0] sram [0:255];
  logic          pre_we = 1'b0;
  logic [7:0]    pre_idx = '0;
  logic [DW-1:0] pre_dat = '0;
  always @(posedge clk) begin
    if (pre_we) sram[pre_idx] <= pre_dat;
    else if (rst && bus.sram_cs && bus.sram_we) sram[bus.sram_addr[9:2]] <= bus.sram_wdata;
  end
  assign bus.sram_rdata = sram[bus.sram_addr[9:2]];

  // Scoreboard: each ready pulse pops the response expected for that source
  always @(negedge clk) begin : mon
    logic [DW-1:0] e;
    if (bus.if_ready === 1'b1) begin
      grants.push_back(SRC_IF);
      total++;
      if (if_q.size() == 0) begin
        bad++;
        $display("FAIL if_resp: unexpected if_ready, got if_rdata=%h, required no pulse", bus.if_rdata);
      end else begin
        e = if_q.pop_front();
        if (bus.if_rdata !== e) begin
          bad++;
          $display("FAIL if_rdata: got %h, required %h", bus.if_rdata, e);
        end
      end
    end
    if (bus.mem_ready === 1'b1) begin
      grants.push_back(SRC_MEM);
      total++;
      if (mem_q.size() == 0) begin
        bad++;
        $display("FAIL mem_resp: unexpected mem_ready, got mem_rdata=%h, required no pulse", bus.mem_rdata);
      end else begin
        e = mem_q.pop_front();
        if (bus.mem_rdata !== e) begin
          bad++;
          $display("FAIL mem_rdata: got %h, required %h", bus.mem_rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_idx = a[9:2]; pre_dat = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    total += 9;
    if (bus.freeze !== 1'b0)     begin bad++; $display("FAIL rst_freeze: got %b, required 0", bus.freeze); end
    if (bus.sram_cs !== 1'b0)    begin bad++; $display("FAIL rst_sram_cs: got %b, required 0", bus.sram_cs); end
    if (bus.sram_we !== 1'b0)    begin bad++; $display("FAIL rst_sram_we: got %b, required 0", bus.sram_we); end
    if (bus.if_ready !== 1'b0)   begin bad++; $display("FAIL rst_if_ready: got %b, required 0", bus.if_ready); end
    if (bus.mem_ready !== 1'b0)  begin bad++; $display("FAIL rst_mem_ready: got %b, required 0", bus.mem_ready); end
    if (bus.if_rdata !== '0)     begin bad++; $display("FAIL rst_if_rdata: got %h, required 0", bus.if_rdata); end
    if (bus.mem_rdata !== '0)    begin bad++; $display("FAIL rst_mem_rdata: got %h, required 0", bus.mem_rdata); end
    if (bus.sram_addr !== '0)    begin bad++; $display("FAIL rst_sram_addr: got %h, required 0", bus.sram_addr); end
    if (bus.sram_wdata !== '0)   begin bad++; $display("FAIL rst_sram_wdata: got %h, required 0", bus.sram_wdata); end
    tick();
    bus.if_req = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_lone_fetch();
    preload(32'h10, 32'hE3A01005);
    bus.if_addr = 32'h10; bus.if_req = 1'b1;
    if_q.push_back(32'hE3A01005);
    for (int k = 0; k < 6; k++) begin
      logic ef, ec, er;
      ef = (k <= 2); ec = (k == 1 || k == 2); er = (k == 3);
      @(negedge clk);
      total += 3;
      if (bus.freeze !== ef)   begin bad++; $display("FAIL fetch_freeze c%0d: got %b, required %b", k, bus.freeze, ef); end
      if (bus.sram_cs !== ec)  begin bad++; $display("FAIL fetch_cs c%0d: got %b, required %b", k, bus.sram_cs, ec); end
      if (bus.if_ready !== er) begin bad++; $display("FAIL fetch_ready c%0d: got %b, required %b", k, bus.if_ready, er); end
      if (k == 1) begin
        total += 2;
        if (bus.sram_addr !== 32'h10) begin bad++; $display("FAIL fetch_addr: got %h, required 00000010", bus.sram_addr); end
        if (bus.sram_we !== 1'b0)     begin bad++; $display("FAIL fetch_we: got %b, required 0", bus.sram_we); end
      end
      tick();
      if (k == 3) bus.if_req = 1'b0;
    end
  endtask

  task automatic test_write_read();
    bit got;
    bus.mem_wr_en = 1'b1; bus.mem_addr = 32'h40; bus.mem_wdata = 32'hDEADBEEF;
    mem_q.push_back(32'h0);  // no data read yet since reset: mem_rdata stays 0
    for (int k = 0; k < 5; k++) begin
      logic ew, er;
      ew = (k == 1 || k == 2); er = (k == 3);
      @(negedge clk);
      total += 2;
      if (bus.sram_we !== ew)   begin bad++; $display("FAIL wr_we c%0d: got %b, required %b", k, bus.sram_we, ew); end
      if (bus.mem_ready !== er) begin bad++; $display("FAIL wr_ready c%0d: got %b, required %b", k, bus.mem_ready, er); end
      if (k == 1) begin
        total += 2;
        if (bus.sram_addr !== 32'h40)        begin bad++; $display("FAIL wr_addr: got %h, required 00000040", bus.sram_addr); end
        if (bus.sram_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata: got %h, required deadbeef", bus.sram_wdata); end
      end
      tick();
      if (k == 3) bus.mem_wr_en = 1'b0;
    end
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h40;
    mem_q.push_back(32'hDEADBEEF);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.mem_ready === 1'b1) got = 1'b1;
      tick();
    end
    bus.mem_rd_en = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL rd_timeout: got no mem_ready, required one within 20 cycles"); end
  endtask

  task automatic test_reset_mid_access();
    bit got;
    preload(32'h80, 32'h11112222);
    preload(32'h04, 32'h33334444);
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h80;
    tick(); tick();
    rst = 1'b0; bus.mem_rd_en = 1'b0;  // asserted in access cycle 2
    tick();
    @(negedge clk);
    total += 2;
    if (bus.sram_cs !== 1'b0)   begin bad++; $display("FAIL midrst_cs: got %b, required 0", bus.sram_cs); end
    if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready: got %b, required 0", bus.mem_ready); end
    tick();
    rst = 1'b1;
    repeat (3) tick();
    bus.if_addr = 32'h04; bus.if_req = 1'b1;
    if_q.push_back(32'h33334444);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.if_ready === 1'b1) got = 1'b1;
      tick();
    end
    bus.if_req = 1'b0;
    total++;
    if (!got) begin bad++; $display("FAIL midrst_fetch_timeout: got no if_ready, required one within 20 cycles"); end
  endtask

  task automatic test_simultaneous();
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h80;
    bus.if_req = 1'b1;    bus.if_addr = 32'h04;
    mem_q.push_back(32'h11112222);
    if_q.push_back(32'h33334444);
    for (int k = 0; k < 8; k++) begin
      logic ef, em, ei, ec;
      ef = !(k == 3 || k == 7); em = (k == 3); ei = (k == 7);
      ec = (k == 1 || k == 2 || k == 5 || k == 6);
      @(negedge clk);
      total += 4;
      if (bus.freeze !== ef)    begin bad++; $display("FAIL sim_freeze c%0d: got %b, required %b", k, bus.freeze, ef); end
      if (bus.mem_ready !== em) begin bad++; $display("FAIL sim_mem_ready c%0d: got %b, required %b", k, bus.mem_ready, em); end
      if (bus.if_ready !== ei)  begin bad++; $display("FAIL sim_if_ready c%0d: got %b, required %b", k, bus.if_ready, ei); end
      if (bus.sram_cs !== ec)   begin bad++; $display("FAIL sim_cs c%0d: got %b, required %b", k, bus.sram_cs, ec); end
      tick();
      if (k == 3) bus.mem_rd_en = 1'b0;
      if (k == 7) bus.if_req = 1'b0;
    end
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    arb_src_e exp_order [4];
    int nd, ni;
    exp_order = '{SRC_MEM, SRC_IF, SRC_MEM, SRC_IF};
    tick();
    grants.delete();
    nd = 0; ni = 0;
    bus.mem_rd_en = 1'b1; bus.mem_addr = 32'h80; mem_q.push_back(32'h11112222);
    bus.if_req = 1'b1;    bus.if_addr = 32'h04;  if_q.push_back(32'h33334444);
    for (int k = 0; k < 40 && (nd < 2 || ni < 2); k++) begin
      logic sm, si;
      @(negedge clk);
      sm = bus.mem_ready; si = bus.if_ready;
      tick();
      if (sm === 1'b1) begin
        nd++;
        if (nd < 2) begin bus.mem_addr = 32'h40; mem_q.push_back(32'hDEADBEEF); end
        else bus.mem_rd_en = 1'b0;
      end
      if (si === 1'b1) begin
        ni++;
        if (ni < 2) begin bus.if_addr = 32'h10; if_q.push_back(32'hE3A01005); end
        else bus.if_req = 1'b0;
      end
    end
    total++;
    if (grants.size() != 4) begin
      bad++; $display("FAIL rr_count: got %0d grants, required 4", grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (grants[i] !== exp_order[i]) begin
          bad++; $display("FAIL rr_order[%0d]: got %s, required %s", i, grants[i].name(), exp_order[i].name());
        end
      end
    end
  endtask
`endif

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_rd_en = 1'b0; bus.mem_wr_en = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    test_reset();
    test_lone_fetch();
    test_write_read();
    test_reset_mid_access();
    test_simultaneous();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    test_round_robin();
`endif
    repeat (3) tick();
    total++;
    if (if_q.size() != 0 || mem_q.size() != 0) begin
      bad++;
      $display("FAIL leftover: got if_q=%0d mem_q=%0d pending, required 0", if_q.size(), mem_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified SRAM between the instruction-fetch stage and the memory stage of the 5-stage ARM pipeline. It sequences each access through a fixed number of SRAM wait cycles and returns one response per request. While an access is pending or in flight it raises `freeze` so that the fetch stage and the pipeline registers hold. Data accesses from the memory stage take priority over instruction fetches.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `WAIT_CYCLES`, 2, SRAM access cycles per transfer; legal range ≥1

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous active-low reset
- `if_req`  in  1  instruction fetch request, level, held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched instruction, valid while `if_ready`=1
- `if_ready`  out  1  one-cycle response pulse for fetch
- `mem_rd_en`  in  1  data read request, level
- `mem_wr_en`  in  1  data write request, level
- `mem_addr`  in  ADDR_W  data address
- `mem_wdata`  in  DATA_W  write data
- `mem_rdata`  out  DATA_W  read data, valid while `mem_ready`=1
- `mem_ready`  out  1  one-cycle response pulse for data
- `freeze`  out  1  pipeline stall
- `sram_cs`  out  1  SRAM chip select
- `sram_we`  out  1  SRAM write enable
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_wdata`  out  DATA_W  SRAM write data
- `sram_rdata`  in  DATA_W  SRAM read data

## Operation
- FSM states: IDLE, D_ACC, I_ACC, RESP.
- IDLE:
  - If `mem_rd_en` or `mem_wr_en` is high, latch addr, wdata and write flag, then go to D_ACC.
  - Otherwise, if `if_req` is high, latch `if_addr` and go to I_ACC.
  - Otherwise stay in IDLE.
- D_ACC / I_ACC:
  - `sram_cs`=1; `sram_addr` and `sram_wdata` come from the latched registers; `sram_we` = latched write flag (D_ACC only).
  - The wait counter runs 0..WAIT_CYCLES-1.
  - On the last count, capture `sram_rdata` into the response register and go to RESP.
- RESP:
  - Pulse `mem_ready` or `if_ready` according to the granted source.
  - `mem_rdata` / `if_rdata` present the captured word.
  - Go to IDLE.
- Writes: `mem_ready` still pulses; `mem_rdata` holds its previous value.
- If `mem_rd_en` and `mem_wr_en` are both high, the access is treated as a write.
- `freeze` = (IDLE and any request) or D_ACC or I_ACC. It is low in RESP, so the pipeline advances in the same cycle as the ready pulse.
- Requesters must drop or replace their request at the clock edge that ends the ready cycle. IDLE samples fresh requests, so no access is ever repeated.
- Simultaneous `if_req` and a data request: data is served first and fetch waits. After the data access's RESP, the next IDLE grants the fetch.
- Counter width is $clog2(WAIT_CYCLES+1). The counter clears on entry to each access state and does not wrap inside an access.

## Timing
- Request seen in IDLE at cycle 0 → access cycles 1..WAIT_CYCLES → ready at cycle WAIT_CYCLES+1. Latency is WAIT_CYCLES+1.
- Back-to-back throughput is one access per WAIT_CYCLES+2 cycles (the IDLE cycle is included).
- Reset values (`rst`=0 at an edge):
  - state = IDLE.
  - `freeze`, `if_ready`, `mem_ready`, `sram_cs`, `sram_we` = 0.
  - `if_rdata`, `mem_rdata`, `sram_addr`, `sram_wdata` = 0.
- Reset in the middle of an access abandons it. No ready pulse is issued, and `sram_cs` is 0 in the cycle after the reset edge.
- `sram_rdata` is sampled on the rising edge that ends the final access cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`, when defined:
  - On simultaneous requests in IDLE, the grant alternates, going to the source not granted last.
  - A last-grant flag (reset value: fetch) records the previous grant.
  - A lone request is granted immediately regardless of the flag.
- When undefined: fixed data-over-fetch priority and no last-grant flag.

## Structure
- Shared package `arm_mem_pkg`:
  - state enum (IDLE, D_ACC, I_ACC, RESP)
  - grant-source enum (SRC_IF, SRC_MEM)
  - default width constants
- Sub-module `mem_wait_counter`:
  - inputs: clear, enable
  - output: `done` on count WAIT_CYCLES-1
  - parameterized by WAIT_CYCLES
- All other logic lives in `mem_arbiter`.

## Test plan
All scenarios use WAIT_CYCLES=2.
- Reset: hold `rst`=0 for 3 cycles with `if_req`=1 → `freeze`=0, `sram_cs`=0, `if_ready`=0, all data outputs 0.
- Lone fetch: `if_addr`=0x10 and SRAM word 0xE3A01005 → `sram_cs` high for cycles 1–2, `if_ready` pulses at cycle 3 with `if_rdata`=0xE3A01005, `freeze` high in cycles 0–2 only.
- Write then read: write 0xDEADBEEF to 0x40 → `sram_we`=1 for 2 cycles and `mem_ready` at cycle 3; then read 0x40 → `mem_rdata`=0xDEADBEEF.
- Simultaneous data read 0x80 and fetch 0x04 → `mem_ready` at cycle 3, IDLE at 4, `if_ready` at cycle 7; `freeze` low only at cycles 3 and 7.
- Reset asserted in cycle 2 of a read → no `mem_ready`, `sram_cs`=0 next cycle; after release, a new fetch completes normally.
- With `MEM_ARB_ROUND_ROBIN_EN`: two back-to-back simultaneous request pairs → grants in the order MEM, IF, MEM, IF.
